// File: rtl/xbus_row_arbiter.sv
// xbus_row_arbiter
//   Round-robin scheduler that shares the single X data bus between NUM_ROW
//   PE-row feeders. One row at a time is granted for a burst of kernel_size
//   beats. y_tag carries the granted row and x_tag that row's current target
//   column. Each row's column pointer advances after every non-empty burst.
//
//   Optional build macro: XARB_PERF_CNT_EN adds the stat_beats / stat_stall
//   statistics outputs. Without it those ports and counters do not exist.
module xbus_row_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int NUM_ROW    = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          rst_busy,
    input  logic [7:0]                    kernel_size,
    input  logic [NUM_ROW-1:0]            row_req,
    input  logic [NUM_ROW-1:0]            row_valid,
    input  logic [NUM_ROW*DATA_WIDTH-1:0] row_data,
    output logic [NUM_ROW-1:0]            row_ready,
    output logic [NUM_ROW-1:0]            row_gnt,
    output logic                          bus_valid,
    output logic [DATA_WIDTH-1:0]         bus_data,
    input  logic                          bus_ready,
    output logic [$clog2(NUM_ROW)-1:0]    y_tag,
    output logic [$clog2(NUM_COL)-1:0]    x_tag,
    output logic                          busy,
    output logic                          burst_done
`ifdef XARB_PERF_CNT_EN
    ,
    output logic [NUM_ROW*32-1:0]         stat_beats,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int RW = $clog2(NUM_ROW);
    localparam int CW = $clog2(NUM_COL);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROW - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Burst context, captured when the grant is issued.
    logic [RW-1:0]         gnt_row;
    logic [7:0]            klen;
    logic [7:0]            beat_cnt;
    logic                  zero_len;

    // Scheduling pointers that persist across bursts.
    logic [RW-1:0]         rr_ptr;
    logic [CW-1:0]         col_ptr [NUM_ROW];

    // Per-row view of the packed data bus.
    logic [DATA_WIDTH-1:0] row_word [NUM_ROW];

    logic [RW-1:0]         pick;
    logic                  grant_take;
    logic                  beat_fire;
    logic                  burst_end;

    for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_unpack
        assign row_word[gr] = row_data[gr*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requesting row at or after start, wrapping past the last row.
    function automatic logic [RW-1:0] rr_pick(input logic [NUM_ROW-1:0] req,
                                              input logic [RW-1:0]      start);
        logic [RW-1:0] cand;
        logic [RW-1:0] sel;
        logic          found;
        cand  = start;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_ROW; i++) begin
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = (cand == LAST_ROW) ? '0 : cand + RW'(1);
        end
        return sel;
    endfunction

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == LAST_ROW) ? '0 : r + RW'(1);
    endfunction

    function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
        return (c == LAST_COL) ? '0 : c + CW'(1);
    endfunction

    assign pick = rr_pick(row_req, rr_ptr);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus/tag outputs; flush overrides everything at the end.
    always_comb begin
        state_nxt  = state;
        grant_take = 1'b0;
        beat_fire  = 1'b0;
        burst_end  = 1'b0;
        row_gnt    = '0;
        row_ready  = '0;
        bus_valid  = 1'b0;
        bus_data   = '0;
        busy       = 1'b0;
        burst_done = 1'b0;
        y_tag      = '0;
        x_tag      = '0;

        case (state)
            ST_IDLE: begin
                if ((|row_req) && !rst_busy) begin
                    grant_take = 1'b1;
                    // An empty burst still reports completion, but moves no data.
                    state_nxt  = (kernel_size == 8'd0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                busy               = 1'b1;
                y_tag              = gnt_row;
                x_tag              = col_ptr[gnt_row];
                row_gnt[gnt_row]   = 1'b1;
                bus_valid          = row_valid[gnt_row];
                bus_data           = row_valid[gnt_row] ? row_word[gnt_row] : '0;
                row_ready[gnt_row] = bus_ready;
                beat_fire          = row_valid[gnt_row] & bus_ready;
                // klen is at least 1 here, so klen-1 never underflows.
                if (beat_fire && (beat_cnt == klen - 8'd1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                y_tag      = gnt_row;
                x_tag      = col_ptr[gnt_row];
                burst_end  = 1'b1;
                burst_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_nxt  = ST_IDLE;
            grant_take = 1'b0;
            beat_fire  = 1'b0;
            burst_end  = 1'b0;
            bus_valid  = 1'b0;
            bus_data   = '0;
            row_ready  = '0;
            burst_done = 1'b0;
        end
    end

    // Burst context, beat counter and the round-robin / column pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_row  <= '0;
            klen     <= '0;
            beat_cnt <= '0;
            zero_len <= 1'b0;
            rr_ptr   <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                col_ptr[r] <= '0;
            end
        end else if (flush) begin
            gnt_row  <= '0;
            klen     <= '0;
            beat_cnt <= '0;
            zero_len <= 1'b0;
            rr_ptr   <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                col_ptr[r] <= '0;
            end
        end else begin
            if (grant_take) begin
                gnt_row  <= pick;
                klen     <= kernel_size;
                beat_cnt <= '0;
                zero_len <= (kernel_size == 8'd0);
            end
            if (beat_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (burst_end) begin
                rr_ptr   <= next_row(gnt_row);
                beat_cnt <= '0;
                if (!zero_len) begin
                    col_ptr[gnt_row] <= next_col(col_ptr[gnt_row]);
                end
            end
        end
    end

`ifdef XARB_PERF_CNT_EN
    logic [31:0] beat_ctr [NUM_ROW];
    logic [31:0] stall_ctr;
    logic        stall_hit;

    assign stall_hit = (state == ST_XFER) && bus_valid && !bus_ready;

    // Saturating per-row beat counters and the shared stall counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_ctr <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                beat_ctr[r] <= '0;
            end
        end else if (flush) begin
            stall_ctr <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                beat_ctr[r] <= '0;
            end
        end else begin
            if (beat_fire && (beat_ctr[gnt_row] != '1)) begin
                beat_ctr[gnt_row] <= beat_ctr[gnt_row] + 32'd1;
            end
            if (stall_hit && (stall_ctr != '1)) begin
                stall_ctr <= stall_ctr + 32'd1;
            end
        end
    end

    for (genvar gs = 0; gs < NUM_ROW; gs++) begin : g_stat
        assign stat_beats[gs*32 +: 32] = beat_ctr[gs];
    end
    assign stat_stall = stall_ctr;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_xbus_row_arbiter.sv
// Directed bench for xbus_row_arbiter with a cycle-level reference model
// built from the scheduling rules, plus hand-computed burst/beat expectations.
module tb_xbus_row_arbiter;

    localparam int NR = 2;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        rst_busy;
    logic [7:0]  kernel_size;
    logic [1:0]  row_req;
    logic [1:0]  row_valid;
    logic [31:0] row_data;
    logic [1:0]  row_ready;
    logic [1:0]  row_gnt;
    logic        bus_valid;
    logic [15:0] bus_data;
    logic        bus_ready;
    logic [0:0]  y_tag;
    logic [1:0]  x_tag;
    logic        busy;
    logic        burst_done;
`ifdef XARB_PERF_CNT_EN
    logic [63:0] stat_beats;
    logic [31:0] stat_stall;
`endif

    always #5 clk = ~clk;

    xbus_row_arbiter #(.DATA_WIDTH(16), .NUM_COL(NC), .NUM_ROW(NR)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .rst_busy(rst_busy),
        .kernel_size(kernel_size), .row_req(row_req), .row_valid(row_valid),
        .row_data(row_data), .row_ready(row_ready), .row_gnt(row_gnt),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready),
        .y_tag(y_tag), .x_tag(x_tag), .busy(busy), .burst_done(burst_done)
`ifdef XARB_PERF_CNT_EN
        , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Feeders: row0 emits 0x1000+k, row1 emits 0x2000+k for its k-th accepted beat.
    logic [15:0] feed_idx [NR];
    assign row_data = {16'h2000 + feed_idx[1], 16'h1000 + feed_idx[0]};

    // Observation logs.
    int          g_row[$];
    int          g_col[$];
    logic [15:0] beats[$];
    int          n_done;
    bit          prev_busy;

    // Reference model: 0 = no burst, 1 = moving beats, 2 = completion cycle.
    int m_phase, m_row, m_left, m_rr;
    bit m_zero;
    int m_col [NR];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance model/feeders after the rising edge.
    task automatic cyc();
        logic [1:0]  e_gnt, e_rdy, acc;
        logic        e_bv, e_busy, e_done, clr;
        logic [15:0] e_bd, word;
        logic [0:0]  e_y;
        logic [1:0]  e_x;
        int          n_phase, n_row, n_left, n_rr;
        bit          n_zero;
        int          n_col [NR];

        @(negedge clk);
        e_gnt = '0; e_rdy = '0; e_bv = 1'b0; e_bd = '0;
        e_busy = 1'b0; e_done = 1'b0; e_y = '0; e_x = '0;
        n_phase = m_phase; n_row = m_row; n_left = m_left; n_rr = m_rr;
        n_zero = m_zero; n_col = m_col;
        if (!rstn) begin
            n_phase = 0; n_rr = 0; n_left = 0; n_row = 0; n_zero = 0;
            for (int r = 0; r < NR; r++) n_col[r] = 0;
        end else begin
            word = (m_row == 0) ? row_data[15:0] : row_data[31:16];
            if (m_phase != 0) begin
                e_busy = 1'b1;
                e_y    = 1'(m_row);
                e_x    = 2'(m_col[m_row]);
            end
            if (m_phase == 1) begin
                e_gnt = (m_row == 0) ? 2'b01 : 2'b10;
                if (!flush) begin
                    e_bv  = row_valid[m_row];
                    e_rdy = bus_ready ? e_gnt : 2'b00;
                end
                e_bd = e_bv ? word : 16'h0;
            end
            if (m_phase == 2) e_done = !flush;

            if (flush) begin
                n_phase = 0; n_rr = 0;
                for (int r = 0; r < NR; r++) n_col[r] = 0;
            end else if (m_phase == 0) begin
                if (row_req != 0 && !rst_busy) begin
                    for (int i = 0; i < NR; i++) begin
                        if (row_req[(m_rr + i) % NR]) begin
                            n_row = (m_rr + i) % NR;
                            break;
                        end
                    end
                    n_left  = int'(kernel_size);
                    n_zero  = (kernel_size == 0);
                    n_phase = n_zero ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (e_bv && bus_ready) begin
                    n_left = m_left - 1;
                    if (n_left == 0) n_phase = 2;
                end
            end else begin
                if (!m_zero) n_col[m_row] = (m_col[m_row] + 1) % NC;
                n_rr    = (m_row + 1) % NR;
                n_phase = 0;
            end
        end

        n_vec++;
        if ({row_gnt, row_ready, bus_valid, bus_data, y_tag, x_tag, busy, burst_done} !==
            {e_gnt, e_rdy, e_bv, e_bd, e_y, e_x, e_busy, e_done}) begin
            n_err++;
            $display("FAIL cycle t=%0t: got gnt=%b rdy=%b bv=%b bd=%h y=%0d x=%0d busy=%b done=%b, expected gnt=%b rdy=%b bv=%b bd=%h y=%0d x=%0d busy=%b done=%b",
                     $time, row_gnt, row_ready, bus_valid, bus_data, y_tag, x_tag, busy, burst_done,
                     e_gnt, e_rdy, e_bv, e_bd, e_y, e_x, e_busy, e_done);
        end

        if (busy && !prev_busy) begin
            g_row.push_back(int'(y_tag));
            g_col.push_back(int'(x_tag));
        end
        prev_busy = busy;
        if (bus_valid && bus_ready) beats.push_back(bus_data);
        if (burst_done) n_done++;
        acc = row_ready & row_valid;
        clr = !rstn || flush;

        @(posedge clk);
        #1;
        m_phase = n_phase; m_row = n_row; m_left = n_left; m_rr = n_rr;
        m_zero = n_zero; m_col = n_col;
        for (int r = 0; r < NR; r++) begin
            if (clr) feed_idx[r] = '0;
            else if (acc[r]) feed_idx[r] = feed_idx[r] + 16'd1;
        end
    endtask

    task automatic clear_logs();
        g_row.delete();
        g_col.delete();
        beats.delete();
        n_done = 0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        clear_logs();
    endtask

    task automatic wait_grants(input int n);
        int budget = 400;
        while (g_row.size() < n && budget > 0) begin
            cyc();
            budget--;
        end
        check("grant_wait", g_row.size(), n);
    endtask

    task automatic wait_beats(input int n);
        int budget = 100;
        while (beats.size() < n && budget > 0) begin
            cyc();
            budget--;
        end
        check("beat_wait", beats.size(), n);
    endtask

    task automatic wait_idle();
        int budget = 400;
        cyc();
        while (busy && budget > 0) begin
            cyc();
            budget--;
        end
        check("idle_wait", busy, 0);
    endtask

    initial begin
        int exp_col [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        m_phase = 0; m_row = 0; m_left = 0; m_rr = 0; m_zero = 0;
        for (int r = 0; r < NR; r++) begin
            m_col[r] = 0;
            feed_idx[r] = '0;
        end
        prev_busy = 0;
        n_done = 0;
        rstn = 1'b0; flush = 1'b0; rst_busy = 1'b0; kernel_size = 8'd2;
        row_req = 2'b11; row_valid = 2'b11; bus_ready = 1'b1;

        // Reset with both rows requesting.
        repeat (3) cyc();
        check("rst_gnt", row_gnt, 0);
        check("rst_outs", {bus_valid, busy, burst_done, row_ready}, 0);
        check("rst_tags", {y_tag, x_tag, bus_data}, 0);
        rstn = 1'b1;
        cyc();
        row_req = 2'b00;
        check("rst_first_gnt", row_gnt, 2'b01);
        check("rst_first_y", y_tag, 0);
        wait_idle();

        // Single burst on row0, repeated once to see the column advance.
        do_flush();
        row_req = 2'b01; kernel_size = 8'd5;
        cyc();
        check("lat_gnt", row_gnt, 2'b01);
        wait_grants(2);
        row_req = 2'b00;
        wait_idle();
        check("sb_rows", {g_row[0][7:0], g_row[1][7:0]}, 0);
        check("sb_x2", g_col[1], 1);
        check("sb_nbeats", beats.size(), 10);
        for (int i = 0; i < 10; i++) check("sb_beat", beats[i], 32'h1000 + i);
        check("sb_done", n_done, 2);

        // Round robin with both rows held.
        do_flush();
        row_req = 2'b11; kernel_size = 8'd3;
        wait_grants(10);
        row_req = 2'b00;
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            check("rr_row", g_row[i], i % 2);
            check("rr_col", g_col[i], exp_col[i]);
        end
        check("rr_beat3", beats[3], 32'h2000);
        check("rr_beat6", beats[6], 32'h1003);
        check("rr_done", n_done, 10);

        // Backpressure: bus_ready alternates starting high on the first beat cycle.
        do_flush();
        row_req = 2'b01; kernel_size = 8'd4;
        cyc();
        row_req = 2'b00; bus_ready = 1'b1;
        repeat (12) begin
            cyc();
            bus_ready = ~bus_ready;
        end
        check("bp_nbeats", beats.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_beat", beats[i], 32'h1000 + i);
        check("bp_done", n_done, 1);
`ifdef XARB_PERF_CNT_EN
        check("bp_stall", stat_stall, 3);
        check("bp_stat_beats", stat_beats[31:0], 4);
`endif
        bus_ready = 1'b1;

        // Flush in the middle of a burst after pointers have moved.
        do_flush();
        row_req = 2'b01; kernel_size = 8'd1;
        wait_grants(1);
        row_req = 2'b00;
        wait_idle();
        clear_logs();
        row_req = 2'b01; kernel_size = 8'd5;
        wait_grants(1);
        row_req = 2'b00;
        check("fl_x_before", g_col[0], 1);
        wait_beats(2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fl_idle", {busy, row_gnt}, 0);
        cyc();
        check("fl_nbeats", beats.size(), 2);
        check("fl_nodone", n_done, 0);
        clear_logs();
        row_req = 2'b11; kernel_size = 8'd1;
        wait_grants(1);
        row_req = 2'b00;
        check("fl_rr_cleared", g_row[0], 0);
        check("fl_col_cleared", g_col[0], 0);
        wait_idle();

        // Zero-length burst: completes, moves no data, keeps the column.
        do_flush();
        row_req = 2'b01; kernel_size = 8'd0;
        wait_grants(1);
        row_req = 2'b00;
        wait_idle();
        check("k0_nbeats", beats.size(), 0);
        check("k0_done", n_done, 1);
        clear_logs();
        row_req = 2'b01; kernel_size = 8'd1;
        wait_grants(1);
        row_req = 2'b00;
        wait_idle();
        check("k0_x_kept", g_col[0], 0);
        check("k0_next_beats", beats.size(), 1);

        // rst_busy holds off new grants but not a running burst.
        do_flush();
        rst_busy = 1'b1; row_req = 2'b01; kernel_size = 8'd2;
        repeat (5) cyc();
        check("rb_no_grant", g_row.size(), 0);
        rst_busy = 1'b0;
        wait_grants(1);
        row_req = 2'b00; rst_busy = 1'b1;
        check("rb_row", g_row[0], 0);
        wait_idle();
        check("rb_beats", beats.size(), 2);
        rst_busy = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
